fios_operand_feeder: RTL and testbench

FIOS_OPERAND_FEEDER -- requirements
Module: fios_operand_feeder

---
 rtl/fios_pkg.sv | 22 ++
 rtl/fios_operand_bank.sv | 57 +++++
 rtl/fios_operand_feeder.sv | 173 +++++++++++++++++
 tb/tb_fios_operand_feeder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fios_pkg.sv
// Shared types for the FIOS operand feeder.
// Word width, operand select and feeder state encodings.
package fios_pkg;
  localparam int WORD_W = 17;

  typedef enum logic [1:0] {
    SEL_X   = 2'd0,
    SEL_Y   = 2'd1,
    SEL_N   = 2'd2,
    SEL_NP0 = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fios_operand_bank.sv
// One operand bank: S words, write/read pointers with wrap,
// full flag and a rearm flag that makes the next load restart at block 0.
module fios_operand_bank
  import fios_pkg::*;
#(
  parameter int S = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rearm,
  input  logic              rd_clr,
  input  logic              rd_adv,
  output logic [WORD_W-1:0] head,
  output logic              rd_last,
  output logic              full,
  output logic              ready
);
  localparam int AW = ptr_w(S);
  localparam logic [AW-1:0] LAST = AW'(S - 1);

  logic [WORD_W-1:0] mem [S];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wa;
  logic              stale;

  assign wa = stale ? '0 : wr_ptr;

  always_ff @(posedge clock_i) begin
    if (wr_en) mem[wa] <= wr_data;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      stale  <= 1'b0;
    end else begin
      if (rearm) stale <= 1'b1;
      if (wr_en) begin
        stale  <= 1'b0;
        full   <= (wa == LAST);
        wr_ptr <= (wa == LAST) ? '0 : wa + 1'b1;
      end
      if (rd_clr) rd_ptr <= '0;
      else if (rd_adv)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  assign head    = mem[rd_ptr];
  assign rd_last = (rd_ptr == LAST);
  assign ready   = !full || stale;
endmodule

// File: rtl/fios_operand_feeder.sv
// Feeds X, Y, n blocks and n'0 to a FIOS Montgomery PE chain.
// Optional sticky protocol error flag: define FIOS_FEEDER_ERR_EN.
module fios_operand_feeder
  import fios_pkg::*;
#(
  parameter int s = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [1:0]        load_sel_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              Y_fetch_i,
  input  logic              n_fetch_i,
  output logic [WORD_W-1:0] Y_o,
  output logic [WORD_W-1:0] n_o,
  input  logic              shift_X_i,
  output logic [WORD_W-1:0] X_o,
  output logic [WORD_W-1:0] n_prime_0_o,
  output logic              err_o
);
  state_e            state;
  sel_e              sel;
  logic              idle;
  logic              run;
  logic              accept;
  logic              go;
  logic [2:0]        wr_en;
  logic [2:0]        adv;
  logic [2:0]        full;
  logic [2:0]        ready;
  logic [2:0]        last;
  logic [WORD_W-1:0] head [3];
  logic [WORD_W-1:0] np0;
  logic              np0_vld;
  logic              unused_last;

  assign sel  = sel_e'(load_sel_i);
  assign idle = (state == ST_IDLE);
  assign run  = (state == ST_RUN);

  always_comb begin
    load_ready_o = 1'b0;
    if (reset_i && idle) begin
      unique case (sel)
        SEL_X:   load_ready_o = ready[0];
        SEL_Y:   load_ready_o = ready[1];
        SEL_N:   load_ready_o = ready[2];
        SEL_NP0: load_ready_o = 1'b1;
      endcase
    end
  end

  assign accept = load_valid_i && load_ready_o;
  assign wr_en  = {accept && (sel == SEL_N),
                   accept && (sel == SEL_Y),
                   accept && (sel == SEL_X)};
  assign go     = idle && start_i && (&full) && np0_vld;
  assign adv    = {run && n_fetch_i,
                   run && Y_fetch_i,
                   run && shift_X_i};

  fios_operand_bank #(.S(s)) u_bank_x (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .wr_en   (wr_en[0]),
    .wr_data (load_data_i),
    .rearm   (done_o),
    .rd_clr  (go),
    .rd_adv  (adv[0]),
    .head    (head[0]),
    .rd_last (last[0]),
    .full    (full[0]),
    .ready   (ready[0])
  );

  fios_operand_bank #(.S(s)) u_bank_y (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .wr_en   (wr_en[1]),
    .wr_data (load_data_i),
    .rearm   (done_o),
    .rd_clr  (go),
    .rd_adv  (adv[1]),
    .head    (head[1]),
    .rd_last (last[1]),
    .full    (full[1]),
    .ready   (ready[1])
  );

  fios_operand_bank #(.S(s)) u_bank_n (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .wr_en   (wr_en[2]),
    .wr_data (load_data_i),
    .rearm   (done_o),
    .rd_clr  (go),
    .rd_adv  (adv[2]),
    .head    (head[2]),
    .rd_last (last[2]),
    .full    (full[2]),
    .ready   (ready[2])
  );

  // Y and n wrap freely; only the X pointer ends a run.
  assign unused_last = ^last[2:1];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= ST_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      np0     <= '0;
      np0_vld <= 1'b0;
    end else begin
      if (accept && (sel == SEL_NP0)) begin
        np0     <= load_data_i;
        np0_vld <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            state  <= ST_RUN;
            busy_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (adv[0] && last[0]) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  assign Y_o         = run ? head[1] : '0;
  assign n_o         = run ? head[2] : '0;
  assign X_o         = run ? head[0] : '0;
  assign n_prime_0_o = np0;

`ifdef FIOS_FEEDER_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = (!run && (Y_fetch_i || n_fetch_i || shift_X_i))
                || (idle && start_i && !go)
                || (run && load_valid_i);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_fios_operand_feeder.sv
// Bench for fios_operand_feeder (s=4): directed scenarios plus
// random traffic checked against an operand-queue reference model.
module tb_fios_operand_feeder;
  localparam int S = 4;
`ifdef FIOS_FEEDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        load_valid_i;
  logic        load_ready_o;
  logic [1:0]  load_sel_i;
  logic [16:0] load_data_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        Y_fetch_i;
  logic        n_fetch_i;
  logic [16:0] Y_o;
  logic [16:0] n_o;
  logic        shift_X_i;
  logic [16:0] X_o;
  logic [16:0] n_prime_0_o;
  logic        err_o;

  fios_operand_feeder #(.s(S)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_sel_i   (load_sel_i),
    .load_data_i  (load_data_i),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .Y_fetch_i    (Y_fetch_i),
    .n_fetch_i    (n_fetch_i),
    .Y_o          (Y_o),
    .n_o          (n_o),
    .shift_X_i    (shift_X_i),
    .X_o          (X_o),
    .n_prime_0_o  (n_prime_0_o),
    .err_o        (err_o)
  );

  always #5 clock_i = ~clock_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: banks as arrays with fill counts (0=X,1=Y,2=n).
  int m_mem [3][S];
  int m_fill [3];
  bit m_reload [3];
  int m_np0;
  bit m_np0v;
  int m_mode;
  int m_xp, m_yp, m_np;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic model_rst();
    for (int b = 0; b < 3; b++) begin
      m_fill[b]   = 0;
      m_reload[b] = 1'b0;
    end
    m_np0  = 0;
    m_np0v = 1'b0;
    m_mode = 0;
    m_xp   = 0;
    m_yp   = 0;
    m_np   = 0;
    m_err  = 1'b0;
  endtask

  function automatic bit exp_ready();
    if (!reset_i || m_mode != 0) return 1'b0;
    if (load_sel_i == 2'd3) return 1'b1;
    return (m_fill[load_sel_i] < S) || m_reload[load_sel_i];
  endfunction

  task automatic compare();
    check("load_ready", 32'(load_ready_o), 32'(exp_ready()));
    check("busy", 32'(busy_o), 32'(m_mode != 0));
    check("done", 32'(done_o), 32'(m_mode == 2));
    check("Y_o", 32'(Y_o), (m_mode == 1) ? m_mem[1][m_yp] : 0);
    check("n_o", 32'(n_o), (m_mode == 1) ? m_mem[2][m_np] : 0);
    check("X_o", 32'(X_o), (m_mode == 1) ? m_mem[0][m_xp] : 0);
    check("np0", 32'(n_prime_0_o), m_np0);
    check("err", 32'(err_o), 32'(m_err));
  endtask

  task automatic model_clk();
    bit rdy, can_go;
    int b;
    if (!reset_i) begin
      model_rst();
      return;
    end
    case (m_mode)
      0: begin
        rdy = exp_ready();
        can_go = m_np0v && m_fill[0] == S && m_fill[1] == S
                 && m_fill[2] == S;
        if (load_valid_i && rdy) begin
          if (load_sel_i == 2'd3) begin
            m_np0  = int'(load_data_i);
            m_np0v = 1'b1;
          end else begin
            b = int'(load_sel_i);
            if (m_reload[b]) begin
              m_fill[b]   = 0;
              m_reload[b] = 1'b0;
            end
            m_mem[b][m_fill[b]] = int'(load_data_i);
            m_fill[b]++;
          end
        end
        if (start_i) begin
          if (can_go) begin
            m_mode = 1;
            m_xp = 0;
            m_yp = 0;
            m_np = 0;
          end else m_err = m_err | ERR_EN;
        end
        if (Y_fetch_i || n_fetch_i || shift_X_i) m_err = m_err | ERR_EN;
      end
      1: begin
        if (load_valid_i) m_err = m_err | ERR_EN;
        m_yp = (m_yp + int'(Y_fetch_i)) % S;
        m_np = (m_np + int'(n_fetch_i)) % S;
        if (shift_X_i) begin
          if (m_xp == S - 1) begin
            m_mode = 2;
            m_xp = 0;
          end else m_xp++;
        end
      end
      default: begin
        m_mode = 0;
        for (int i = 0; i < 3; i++) m_reload[i] = 1'b1;
        if (Y_fetch_i || n_fetch_i || shift_X_i) m_err = m_err | ERR_EN;
      end
    endcase
  endtask

  // Called at posedge+1: sample at negedge, then advance one clock.
  task automatic tick();
    #4;
    compare();
    @(posedge clock_i);
    model_clk();
    #1;
  endtask

  task automatic idle_inputs();
    load_valid_i = 1'b0;
    load_sel_i   = 2'd0;
    load_data_i  = '0;
    start_i      = 1'b0;
    Y_fetch_i    = 1'b0;
    n_fetch_i    = 1'b0;
    shift_X_i    = 1'b0;
  endtask

  task automatic load(input logic [1:0] sel, input int data);
    load_valid_i = 1'b1;
    load_sel_i   = sel;
    load_data_i  = 17'(data);
    tick();
    idle_inputs();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic shift_once();
    shift_X_i = 1'b1;
    tick();
    shift_X_i = 1'b0;
  endtask

  task automatic async_reset();
    reset_i = 1'b0;
    #1;
    model_rst();
    compare();
    tick();
    reset_i = 1'b1;
  endtask

  task automatic load_all(input int base);
    for (int i = 0; i < S; i++) load(2'd0, base + 1 + i);
    for (int i = 0; i < S; i++) load(2'd1, base + 5 + i);
    for (int i = 0; i < S; i++) load(2'd2, base + 9 + i);
  endtask

  int ys [6] = '{6, 7, 8, 5, 6, 7};

  initial begin
    reset_i = 1'b1;
    idle_inputs();
    model_rst();
    #2;
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    tick();
    check("rst_busy", 32'(busy_o), 0);
    check("rst_ready", 32'(load_ready_o), 0);
    reset_i = 1'b1;
    tick();

    load_all(0);
    load(2'd3, 'h1FFFF);
    pulse_start();
    check("run_busy", 32'(busy_o), 1);
    check("run_Y0", 32'(Y_o), 5);
    check("run_n0", 32'(n_o), 9);
    check("run_X0", 32'(X_o), 1);
    check("run_np0", 32'(n_prime_0_o), 'h1FFFF);

    for (int i = 0; i < 6; i++) begin
      Y_fetch_i = 1'b1;
      tick();
      Y_fetch_i = 1'b0;
      check("y_seq", 32'(Y_o), ys[i]);
      check("n_hold", 32'(n_o), 9);
    end

    for (int i = 0; i < S; i++) begin
      shift_once();
      if (i < S - 1) check("x_seq", 32'(X_o), i + 2);
      else check("done_pulse", 32'(done_o), 1);
    end
    tick();
    check("done_clr", 32'(done_o), 0);
    check("idle_busy", 32'(busy_o), 0);
    check("idle_Y", 32'(Y_o), 0);

    // Rerun on retained operands, dual fetch.
    pulse_start();
    check("rerun_busy", 32'(busy_o), 1);
    Y_fetch_i = 1'b1;
    n_fetch_i = 1'b1;
    tick();
    idle_inputs();
    check("dual_Y", 32'(Y_o), 6);
    check("dual_n", 32'(n_o), 10);
    for (int i = 0; i < S; i++) shift_once();
    tick();

    // Reload X only: partial reload blocks start.
    load(2'd0, 21);
    pulse_start();
    check("partial_refused", 32'(busy_o), 0);
    for (int i = 1; i < S; i++) load(2'd0, 21 + i);
    pulse_start();
    check("reload_X0", 32'(X_o), 21);
    check("reload_Y0", 32'(Y_o), 5);
    tick();

    // Asynchronous reset mid-run.
    reset_i = 1'b0;
    #1;
    model_rst();
    check("arst_busy", 32'(busy_o), 0);
    check("arst_X", 32'(X_o), 0);
    compare();
    tick();
    reset_i = 1'b1;
    pulse_start();
    check("post_rst_refused", 32'(busy_o), 0);

    // Y holds only three words.
    async_reset();
    for (int i = 0; i < S; i++) load(2'd0, 31 + i);
    for (int i = 0; i < S - 1; i++) load(2'd1, 41 + i);
    for (int i = 0; i < S; i++) load(2'd2, 51 + i);
    load(2'd3, 77);
    pulse_start();
    check("short_Y_busy", 32'(busy_o), 0);
    check("short_Y_err", 32'(err_o), 32'(ERR_EN));
    tick();

    // Random traffic.
    async_reset();
    for (int c = 0; c < 3000; c++) begin
      load_valid_i = ($urandom_range(0, 1) == 1);
      load_sel_i   = 2'($urandom_range(0, 3));
      load_data_i  = 17'($urandom);
      start_i      = ($urandom_range(0, 7) == 0);
      Y_fetch_i    = ($urandom_range(0, 2) == 0);
      n_fetch_i    = ($urandom_range(0, 2) == 0);
      shift_X_i    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) begin
        idle_inputs();
        async_reset();
      end else begin
        tick();
      end
    end
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
